// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial packet receiver.
package serial_frame_rx_pkg;

  // Leading bit of every serial word
  typedef enum logic {
    DATA = 1'b0,
    CMD  = 1'b1
  } payload_type_t;

  // Packet assembly state
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } rx_state_t;

  // Bit positions inside pkt_status
  localparam int ST_PARITY = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_W      = 4;

endpackage

// File: rtl/serial_frame_rx_word.sv
// Serial word deserialiser: shift register plus bit counter.
// Word completion is flagged combinationally on the edge that samples the
// parity bit, so the packet layer can act on that same edge.
module serial_word_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable_n,
  input  logic              i_din,
  output logic              o_word_done,
  output logic              o_word_type,
  output logic [DATA_W-1:0] o_word_data,
  output logic              o_parity_ok,
  output logic              o_abort
);

  localparam int WORD_W = DATA_W + 2;
  localparam int BCNT_W = $clog2(WORD_W);

  logic [WORD_W-2:0] r_shift;
  logic [BCNT_W-1:0] r_bcnt;
  logic [WORD_W-1:0] w_word;

  // Full word = earlier bits from the shifter plus the bit on the wire now
  assign w_word      = {r_shift, i_din};
  assign o_word_done = !i_enable_n && (r_bcnt == BCNT_W'(WORD_W - 1));
  assign o_abort     = i_enable_n && (r_bcnt != '0);
  assign o_word_type = w_word[WORD_W-1];
  assign o_word_data = w_word[WORD_W-2:1];
  // parity = ^{type,data}, so XOR over the whole word is 0 when good
  assign o_parity_ok = ~(^w_word);

  // Shift in sampled bits; counter wraps after the parity bit, clears on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (!i_enable_n) begin
      r_shift <= {r_shift[WORD_W-3:0], i_din};
      r_bcnt  <= o_word_done ? '0 : r_bcnt + 1'b1;
    end else if (o_abort) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Packet receiver: gathers DATA words until a CMD word, then presents the
// packet on a valid/ready port through an output register that is separate
// from the accumulation buffer.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MAX_WORDS = 4,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_n,
  input  logic                        din,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [DATA_W-1:0]           pkt_cmd,
  output logic [MAX_WORDS*DATA_W-1:0] pkt_data,
  output logic [CNT_W-1:0]            pkt_len,
  output logic [ST_W-1:0]             pkt_status,
  output logic                        frame_abort,
  output logic                        pkt_lost
);

  logic              w_word_done, w_word_type, w_parity_ok, w_abort;
  logic [DATA_W-1:0] w_word_data;
  logic              w_pkt_done, w_data_word;
  logic [ST_W-1:0]   w_status;

  rx_state_t                        r_state;
  logic [MAX_WORDS-1:0][DATA_W-1:0] r_buf;
  logic [CNT_W-1:0]                 r_len;
  logic                             r_par_err, r_ovf;

  logic                        r_valid, r_abort, r_lost;
  logic [DATA_W-1:0]           r_cmd;
  logic [MAX_WORDS*DATA_W-1:0] r_data;
  logic [CNT_W-1:0]            r_olen;
  logic [ST_W-1:0]             r_status;

  serial_word_rx #(.DATA_W(DATA_W)) u_word (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable_n (enable_n),
    .i_din      (din),
    .o_word_done(w_word_done),
    .o_word_type(w_word_type),
    .o_word_data(w_word_data),
    .o_parity_ok(w_parity_ok),
    .o_abort    (w_abort)
  );

  assign w_pkt_done  = w_word_done && (w_word_type == CMD);
  assign w_data_word = w_word_done && (w_word_type == DATA);

  // Status of the packet completing now, including the CMD word's own parity
  always_comb begin
    w_status            = '0;
    w_status[ST_PARITY] = r_par_err | ~w_parity_ok;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_EMPTY]  = (r_len == '0);
  end

  // Packet state tracking; DONE marks the cycle the packet left for output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!enable_n) r_state <= RECV;
        RECV:    if (w_abort) r_state <= IDLE;
                 else if (w_pkt_done) r_state <= DONE;
        DONE:    r_state <= enable_n ? IDLE : RECV;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Accumulator: cleared whenever a packet ends (completed, lost or aborted)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_len     <= '0;
      r_par_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_abort || w_pkt_done) begin
      r_buf     <= '0;
      r_len     <= '0;
      r_par_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_data_word) begin
      r_par_err <= r_par_err | ~w_parity_ok;
      if (r_len < CNT_W'(MAX_WORDS)) begin
        for (int i = 0; i < MAX_WORDS; i++)
          if (r_len == CNT_W'(i)) r_buf[i] <= w_word_data;
        r_len <= r_len + 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Output register and handshake; a packet arriving while one is stalled is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_cmd    <= '0;
      r_data   <= '0;
      r_olen   <= '0;
      r_status <= '0;
      r_abort  <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_abort <= w_abort;
      r_lost  <= 1'b0;
      if (w_pkt_done) begin
        if (r_valid && !pkt_ready) begin
          r_lost <= 1'b1;
        end else begin
          r_valid  <= 1'b1;
          r_cmd    <= w_word_data;
          r_data   <= r_buf;
          r_olen   <= r_len;
          r_status <= w_status;
        end
      end else if (r_valid && pkt_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign pkt_valid   = r_valid;
  assign pkt_cmd     = r_cmd;
  assign pkt_data    = r_data;
  assign pkt_len     = r_olen;
  assign pkt_status  = r_status;
  assign frame_abort = r_abort;
  assign pkt_lost    = r_lost;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (DATA_W=8, MAX_WORDS=4).
module tb_serial_frame_rx;

  localparam int WORD_W = 10;

  logic        clk = 1'b0;
  logic        rst_n, enable_n, din, pkt_ready;
  logic        pkt_valid, frame_abort, pkt_lost;
  logic [7:0]  pkt_cmd;
  logic [31:0] pkt_data;
  logic [2:0]  pkt_len;
  logic [3:0]  pkt_status;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [2:0]  len;
    logic [3:0]  st;
  } pkt_t;

  pkt_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   n_abort = 0, n_lost = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_cmd    (pkt_cmd),
    .pkt_data   (pkt_data),
    .pkt_len    (pkt_len),
    .pkt_status (pkt_status),
    .frame_abort(frame_abort),
    .pkt_lost   (pkt_lost)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // Monitor: every transfer must match the oldest expected packet
  always @(negedge clk) begin
    if (frame_abort) n_abort++;
    if (pkt_lost) n_lost++;
    if (rst_n && pkt_valid && pkt_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pkt: got cmd=%0h data=%0h len=%0d st=%0b, none expected",
                 pkt_cmd, pkt_data, pkt_len, pkt_status);
      end else begin
        pkt_t e;
        e = sb.pop_front();
        chk("pkt", {pkt_cmd, pkt_data, pkt_len, pkt_status}, e);
      end
    end
  end

  function automatic logic [WORD_W-1:0] mk(input logic t, input logic [7:0] d, input logic bad);
    return {t, d, (^{t, d}) ^ bad};
  endfunction

  // Drive the first nb bits of w, MSB first, one per clock; leave the line idle
  task automatic send_bits(input logic [WORD_W-1:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      enable_n = 1'b0;
      din      = w[WORD_W-1-i];
      @(posedge clk); #1;
    end
    enable_n = 1'b1;
    din      = 1'b0;
  endtask

  task automatic send(input logic t, input logic [7:0] d, input logic bad);
    send_bits(mk(t, d, bad), WORD_W);
  endtask

  task automatic idle(input int n);
    enable_n = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; enable_n = 1'b1; din = 1'b0; pkt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {pkt_valid, pkt_cmd, pkt_data, pkt_len, pkt_status, frame_abort, pkt_lost}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic packet; pkt_valid must be up right after the CMD parity edge
    sb.push_back('{8'h01, 32'h0000_3412, 3'd2, 4'b0000});
    send(1'b0, 8'h12, 1'b0);
    send(1'b0, 8'h34, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    chk("latency_valid", pkt_valid, 1);
    idle(3);

    // Second word with bad parity
    sb.push_back('{8'h01, 32'h0000_3412, 3'd2, 4'b0001});
    send(1'b0, 8'h12, 1'b0);
    send(1'b0, 8'h34, 1'b1);
    send(1'b1, 8'h01, 1'b0);
    idle(3);

    // Overflow: fifth data word dropped
    sb.push_back('{8'hA5, 32'h0403_0201, 3'd4, 4'b0010});
    for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), 1'b0);
    send(1'b1, 8'hA5, 1'b0);
    idle(3);

    // Abort mid-word discards the partial packet too
    send(1'b0, 8'h77, 1'b0);
    send_bits(mk(1'b0, 8'h66, 1'b0), 4);
    @(posedge clk); #1;
    chk("abort_pulse", frame_abort, 1);
    idle(2);
    sb.push_back('{8'h02, 32'h0000_0055, 3'd1, 4'b0000});
    send(1'b0, 8'h55, 1'b0);
    send(1'b1, 8'h02, 1'b0);
    idle(3);

    // Back-pressure: second packet lost, first held unchanged
    pkt_ready = 1'b0;
    sb.push_back('{8'h10, 32'h0000_00AA, 3'd1, 4'b0000});
    send(1'b0, 8'hAA, 1'b0);
    send(1'b1, 8'h10, 1'b0);
    idle(2);
    send(1'b0, 8'hBB, 1'b0);
    send(1'b1, 8'h20, 1'b0);
    chk("lost_pulse", pkt_lost, 1);
    chk("held_pkt", {pkt_valid, pkt_cmd, pkt_data}, {1'b1, 8'h10, 32'h0000_00AA});
    idle(2);
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", pkt_valid, 0);
    idle(2);

    // Lone CMD: empty packet
    sb.push_back('{8'h07, 32'h0, 3'd0, 4'b0100});
    send(1'b1, 8'h07, 1'b0);
    idle(3);

    // Reset mid-word while a packet is held
    pkt_ready = 1'b0;
    send(1'b1, 8'h09, 1'b0);
    send_bits(mk(1'b0, 8'h3C, 1'b0), 3);
    enable_n = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midword", {pkt_valid, pkt_cmd, pkt_data, pkt_len, pkt_status, frame_abort, pkt_lost}, 64'd0);
    enable_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    idle(1);
    sb.push_back('{8'h0F, 32'h0000_003C, 3'd1, 4'b0000});
    send(1'b0, 8'h3C, 1'b0);
    send(1'b1, 8'h0F, 1'b0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    chk("sb_drained", sb.size(), 0);
    chk("abort_count", n_abort, 1);
    chk("lost_count", n_lost, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
